// File: rtl/wb_rr_arbiter_if.sv
// rtl/wb_rr_arbiter_if.sv - pipelined Wishbone bus bundle used by wb_rr_arbiter
interface wb_rr_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_wdat;
  logic [DW/8-1:0] wb_sel;
  logic            wb_cyc;
  logic            wb_stb;
  logic            wb_we;
  logic [DW-1:0]   wb_rdat;
  logic            wb_ack;
  logic            wb_err;
  logic            wb_stall;

  modport master (
    output wb_addr, wb_wdat, wb_sel, wb_cyc, wb_stb, wb_we,
    input  wb_rdat, wb_ack, wb_err, wb_stall
  );

  modport slave (
    input  wb_addr, wb_wdat, wb_sel, wb_cyc, wb_stb, wb_we,
    output wb_rdat, wb_ack, wb_err, wb_stall
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - two-master round-robin pipelined Wishbone arbiter
// Grant is held for a whole cyc; a watchdog aborts transfers the slave never answers.
module wb_rr_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256,
  parameter int OW      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_rr_arbiter_if.slave    m0,
  wb_rr_arbiter_if.slave    m1,
  wb_rr_arbiter_if.master   s,
  output logic [1:0]        gnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  localparam logic [OW-1:0] OUT_MAX = '1;
  localparam logic [15:0]   WD_LAST = 16'(TIMEOUT - 1);

  state_t        state;
  logic          last_gnt;
  logic [OW-1:0] outstanding;
  logic [15:0]   watchdog;

  logic granted, cur, m_cyc, m_stb, full, s_stb, accept, resp, timeout;

  // In ABORT last_gnt already names the aborted master, so cur stays valid there.
  assign granted = (state == GNT0) || (state == GNT1);
  assign cur     = (state == GNT1) || ((state == ABORT) && last_gnt);
  assign m_cyc   = cur ? m1.wb_cyc : m0.wb_cyc;
  assign m_stb   = cur ? m1.wb_stb : m0.wb_stb;
  assign full    = (outstanding == OUT_MAX);
  assign s_stb   = granted && m_cyc && m_stb && !full;
  assign accept  = s_stb && !s.wb_stall;
  assign resp    = s.wb_ack || s.wb_err;
  assign timeout = granted && (outstanding != '0) && (watchdog == WD_LAST) && !resp;
  assign gnt_o   = {state == GNT1, state == GNT0};

  always_comb begin
    s.wb_cyc  = 1'b0;
    s.wb_stb  = 1'b0;
    s.wb_we   = 1'b0;
    s.wb_addr = '0;
    s.wb_wdat = '0;
    s.wb_sel  = '0;
    if (granted) begin
      s.wb_cyc  = m_cyc;
      s.wb_stb  = s_stb;
      s.wb_we   = cur ? m1.wb_we   : m0.wb_we;
      s.wb_addr = cur ? m1.wb_addr : m0.wb_addr;
      s.wb_wdat = cur ? m1.wb_wdat : m0.wb_wdat;
      s.wb_sel  = cur ? m1.wb_sel  : m0.wb_sel;
    end
  end

  always_comb begin
    m0.wb_stall = 1'b1;
    m0.wb_ack   = 1'b0;
    m0.wb_err   = 1'b0;
    m0.wb_rdat  = '0;
    m1.wb_stall = 1'b1;
    m1.wb_ack   = 1'b0;
    m1.wb_err   = 1'b0;
    m1.wb_rdat  = '0;
    if (state == GNT0) begin
      m0.wb_stall = s.wb_stall || full;
      m0.wb_ack   = s.wb_ack;
      m0.wb_err   = s.wb_err || timeout;
      m0.wb_rdat  = s.wb_rdat;
    end else if (state == GNT1) begin
      m1.wb_stall = s.wb_stall || full;
      m1.wb_ack   = s.wb_ack;
      m1.wb_err   = s.wb_err || timeout;
      m1.wb_rdat  = s.wb_rdat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      outstanding <= '0;
      watchdog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          outstanding <= '0;
          watchdog    <= '0;
          if (m0.wb_cyc && (!m1.wb_cyc || last_gnt)) state <= GNT0;
          else if (m1.wb_cyc)                        state <= GNT1;
        end
        GNT0, GNT1: begin
          if (!m_cyc) begin
            state       <= IDLE;
            last_gnt    <= cur;
            outstanding <= '0;
            watchdog    <= '0;
          end else if (timeout) begin
            state       <= ABORT;
            last_gnt    <= cur;
            outstanding <= '0;
            watchdog    <= '0;
          end else begin
            // A response with nothing outstanding is ignored to avoid underflow.
            if (accept && !(resp && outstanding != '0))
              outstanding <= outstanding + 1'b1;
            else if (!accept && resp && outstanding != '0)
              outstanding <= outstanding - 1'b1;
            watchdog <= (resp || outstanding == '0) ? 16'd0 : watchdog + 16'd1;
          end
        end
        ABORT: begin
          if (!m_cyc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - directed self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.AW(32), .DW(32)) m0 ();
  wb_rr_arbiter_if #(.AW(32), .DW(32)) m1 ();
  wb_rr_arbiter_if #(.AW(32), .DW(32)) s ();

  wb_rr_arbiter #(.AW(32), .DW(32), .TIMEOUT(8), .OW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0),
    .m1    (m1),
    .s     (s),
    .gnt_o (gnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // slave model: lat = ack latency in cycles (0 = never acks)
  int          cyc_n, lat, stall_after, stall_len, stall_left, slv_acc;
  int          due_q[$];
  logic [31:0] rdata;
  int          m0_acc, m1_acc, ack0_cnt, err1_cnt, peak;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit s_acc, acc0, acc1;
    s_acc = s.wb_cyc && s.wb_stb && !s.wb_stall;
    acc0  = m0.wb_cyc && m0.wb_stb && !m0.wb_stall;
    acc1  = m1.wb_cyc && m1.wb_stb && !m1.wb_stall;
    if (m0.wb_ack) ack0_cnt++;
    if (m1.wb_err) err1_cnt++;
    @(posedge clk);
    #1;
    cyc_n++;
    if (acc0) m0_acc++;
    if (acc1) m1_acc++;
    if (s_acc) begin
      slv_acc++;
      if (lat > 0) due_q.push_back(cyc_n + lat - 1);
      if (slv_acc == stall_after) stall_left = stall_len;
    end
    s.wb_stall = (stall_left > 0);
    if (stall_left > 0) stall_left--;
    s.wb_ack  = 1'b0;
    s.wb_rdat = '0;
    if (due_q.size() > 0 && due_q[0] == cyc_n) begin
      void'(due_q.pop_front());
      s.wb_ack  = 1'b1;
      s.wb_rdat = rdata;
    end
    #1;
  endtask

  task automatic clear_masters();
    m0.wb_cyc = 0; m0.wb_stb = 0; m0.wb_we = 0; m0.wb_addr = '0; m0.wb_wdat = '0; m0.wb_sel = 4'hF;
    m1.wb_cyc = 0; m1.wb_stb = 0; m1.wb_we = 0; m1.wb_addr = '0; m1.wb_wdat = '0; m1.wb_sel = 4'hF;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_masters();
    s.wb_ack = 0; s.wb_err = 0; s.wb_stall = 0; s.wb_rdat = '0;
    due_q.delete();
    lat = 1; stall_after = 0; stall_len = 0; stall_left = 0; slv_acc = 0; cyc_n = 0;
    m0_acc = 0; m1_acc = 0; ack0_cnt = 0; err1_cnt = 0; rdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [1:0] exp_gnt;

    // reset state
    do_reset();
    check("rst_gnt", gnt, 2'b00);
    check("rst_scyc", s.wb_cyc, 0);
    check("rst_sstb", s.wb_stb, 0);
    check("rst_m0_stall", m0.wb_stall, 1);
    check("rst_m1_stall", m1.wb_stall, 1);
    check("rst_acks", {m0.wb_ack, m1.wb_ack, m0.wb_err, m1.wb_err}, 0);

    // 1: single read by m0
    rdata = 32'hDEADBEEF;
    m0.wb_addr = 32'h0010_0004; m0.wb_cyc = 1; m0.wb_stb = 1;
    #1;
    check("t1_idle_stall", m0.wb_stall, 1);
    tick();
    check("t1_gnt", gnt, 2'b01);
    check("t1_saddr", s.wb_addr, 32'h0010_0004);
    check("t1_m1_stall", m1.wb_stall, 1);
    tick();
    m0.wb_stb = 0;
    #1;
    check("t1_ack", m0.wb_ack, 1);
    check("t1_dat", m0.wb_rdat, 32'hDEADBEEF);
    check("t1_m1_ack", m1.wb_ack, 0);
    check("t1_m1_dat", m1.wb_rdat, 0);
    m0.wb_cyc = 0;
    tick();
    check("t1_release", gnt, 2'b00);
    check("t1_addr_idle", s.wb_addr, 0);

    // 2: contention, then alternating rounds
    do_reset();
    m0.wb_addr = 32'h100; m0.wb_wdat = 32'h1111_0000; m0.wb_we = 1; m0.wb_cyc = 1; m0.wb_stb = 1;
    m1.wb_addr = 32'h200; m1.wb_wdat = 32'h2222_0000; m1.wb_we = 1; m1.wb_cyc = 1; m1.wb_stb = 1;
    tick();
    check("t2_first", gnt, 2'b01);
    check("t2_sdat0", s.wb_wdat, 32'h1111_0000);
    check("t2_swe", s.wb_we, 1);
    tick();
    m0.wb_cyc = 0; m0.wb_stb = 0;
    #1;
    check("t2_ack0", m0.wb_ack, 1);
    check("t2_m1_wait", m1.wb_stall, 1);
    tick();
    check("t2_dead", gnt, 2'b00);
    tick();
    check("t2_second", gnt, 2'b10);
    check("t2_sdat1", s.wb_wdat, 32'h2222_0000);
    tick();
    m1.wb_cyc = 0; m1.wb_stb = 0;
    #1;
    check("t2_ack1", m1.wb_ack, 1);
    tick();
    check("t2_idle", gnt, 2'b00);
    for (int r = 0; r < 4; r++) begin
      m0.wb_cyc = 1; m0.wb_stb = 1; m1.wb_cyc = 1; m1.wb_stb = 1;
      tick();
      exp_gnt = (r % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("t2_round%0d", r), gnt, exp_gnt);
      tick();
      clear_masters();
      tick();
      tick();
    end

    // 3: pipelined burst with stall and 3-cycle ack latency
    do_reset();
    lat = 3; stall_after = 1; stall_len = 2; rdata = 32'hA5A5_0000; peak = 0;
    m0.wb_addr = 32'h1000; m0.wb_cyc = 1; m0.wb_stb = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (m0_acc >= 4) m0.wb_stb = 0;
      m0.wb_addr = 32'h1000 + 32'(4 * m0_acc);
      if (int'(dut.outstanding) > peak) peak = int'(dut.outstanding);
    end
    check("t3_accepted", m0_acc, 4);
    check("t3_acks", ack0_cnt, 4);
    check("t3_peak", peak, 3);
    check("t3_final_out", dut.outstanding, 0);
    clear_masters();
    tick();

    // 4: outstanding limit (OW = 2) with a slave that never acks
    do_reset();
    lat = 0;
    m0.wb_cyc = 1; m0.wb_stb = 1;
    tick();
    tick();
    tick();
    check("t4_not_full", m0.wb_stall, 0);
    tick();
    check("t4_acc3", m0_acc, 3);
    check("t4_stall", m0.wb_stall, 1);
    check("t4_sstb", s.wb_stb, 0);
    check("t4_scyc", s.wb_cyc, 1);
    tick();
    tick();
    check("t4_acc_hold", m0_acc, 3);
    check("t4_slave_acc", slv_acc, 3);
    clear_masters();
    tick();
    check("t4_release", gnt, 2'b00);

    // 5: watchdog timeout (TIMEOUT = 8) on m1
    do_reset();
    lat = 0;
    m1.wb_cyc = 1; m1.wb_stb = 1;
    tick();
    check("t5_gnt", gnt, 2'b10);
    tick();
    m1.wb_stb = 0;
    check("t5_acc", m1_acc, 1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 6) check("t5_err_k6", m1.wb_err, 0);
      if (k == 7) begin
        check("t5_err_k7", m1.wb_err, 1);
        check("t5_scyc_k7", s.wb_cyc, 1);
      end
      if (k == 8) begin
        check("t5_err_k8", m1.wb_err, 0);
        check("t5_scyc_abort", s.wb_cyc, 0);
        check("t5_gnt_abort", gnt, 2'b00);
      end
    end
    check("t5_err_once", err1_cnt, 1);
    s.wb_ack = 1; s.wb_rdat = 32'h0000_0BAD;
    #1;
    check("t5_late_ack", m1.wb_ack, 0);
    check("t5_late_dat", m1.wb_rdat, 0);
    check("t5_abort_stall", m1.wb_stall, 1);
    tick();
    m1.wb_cyc = 0;
    tick();
    m0.wb_cyc = 1;
    tick();
    check("t5_back_idle", gnt, 2'b01);
    clear_masters();
    tick();

    // 6: asynchronous reset in the middle of a burst
    do_reset();
    lat = 3; rdata = 32'h0BAD_F00D;
    m0.wb_cyc = 1; m0.wb_stb = 1;
    tick();
    tick();
    tick();
    check("t6_pre_gnt", gnt, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("t6_scyc", s.wb_cyc, 0);
    check("t6_gnt", gnt, 2'b00);
    check("t6_stalls", {m0.wb_stall, m1.wb_stall}, 2'b11);
    clear_masters();
    ack0_cnt = 0;
    tick();
    tick();
    tick();
    check("t6_no_ack", ack0_cnt, 0);
    rst_n = 1'b1;
    m0.wb_cyc = 1; m1.wb_cyc = 1;
    tick();
    check("t6_after_rst", gnt, 2'b01);
    clear_masters();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Two-master, one-slave round-robin Wishbone (pipelined, with stall) arbiter. It shares a single slave, such as the wb_ram behind the CPU crossbar, between the CPU cluster and a second requester (DMA/debug). It holds the grant for a whole cyc, tracks outstanding accepted strobes and aborts hung transfers with a watchdog.

Parameters:
AW, 32, address width
DW, 32, data width; sel width is DW/8
TIMEOUT, 256, cycles without ack/err, while outstanding > 0, before abort; legal range 2..65535
OW, 4, outstanding-counter width; at most 2^OW-1 strobes in flight

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mX_wb_addr_i  in  AW  master X address (X = 0, 1; the same set exists for both masters)
mX_wb_dat_i  in  DW  master X write data
mX_wb_sel_i  in  DW/8  master X byte select
mX_wb_cyc_i / mX_wb_stb_i / mX_wb_we_i  in  1 each  master X control
mX_wb_dat_o  out  DW  read data to master X
mX_wb_ack_o / mX_wb_err_o / mX_wb_stall_o  out  1 each  responses to master X
s_wb_addr_o / s_wb_dat_o / s_wb_sel_o  out  AW / DW / DW/8  slave request
s_wb_cyc_o / s_wb_stb_o / s_wb_we_o  out  1 each  slave control
s_wb_dat_i  in  DW  slave read data
s_wb_ack_i / s_wb_err_i / s_wb_stall_i  in  1 each  slave responses
gnt_o  out  2  one-hot current grant (debug/status)

Behaviour:
- States: IDLE, GNT0, GNT1, ABORT. The state and the last_gnt bit are registered. All muxing is combinational from the state.
- Reset, asynchronous on rst_n low, effective immediately:
  - state = IDLE, last_gnt = 1 (so master 0 wins the first tie)
  - outstanding = 0, watchdog = 0
  - s_wb_cyc_o = s_wb_stb_o = 0, gnt_o = 0
  - all mX ack and err = 0, all mX stall = 1
- IDLE transitions:
  - Only m0 cyc high -> GNT0 on the next edge.
  - Only m1 cyc high -> GNT1 on the next edge.
  - Both high -> the master not equal to last_gnt.
  - Arbitration latency is 1 cycle; stall stays 1 to both masters while in IDLE.
- GNTx:
  - s_wb_cyc_o = mX cyc. s_wb_stb_o, addr, dat, sel and we are passed through from master X.
  - mX_stall_o = s_wb_stall_i. mX_ack_o, mX_err_o and mX_dat_o are passed through from the slave.
  - The other master sees stall = 1, ack = 0, err = 0 and dat = 0.
  - gnt_o is one-hot for X. s_wb_addr_o, s_wb_dat_o and s_wb_sel_o are 0 outside GNTx.
- Outstanding counter:
  - Increments on mX_stb & ~s_wb_stall_i.
  - Decrements on s_wb_ack_i | s_wb_err_i.
  - A simultaneous increment and decrement leaves it unchanged.
  - When the count equals 2^OW-1, the arbiter forces mX_stall_o = 1 and s_wb_stb_o = 0.
- Release: when mX cyc drops in GNTx -> IDLE, last_gnt = X, outstanding cleared.
  - The other master can be granted no earlier than the cycle after IDLE, so there is one dead cycle and back-to-back grants cannot overlap.
  - A master that keeps cyc high keeps the grant indefinitely; fairness applies only at cyc boundaries.
- Watchdog:
  - Counts while in GNTx with outstanding > 0 and no ack/err.
  - Clears on any ack/err or when outstanding = 0.
  - On reaching TIMEOUT-1 -> ABORT. In that same cycle mX_err_o = 1 for exactly one cycle, produced by the arbiter rather than the slave.
- ABORT:
  - s_wb_cyc_o = s_wb_stb_o = 0.
  - Late slave ack/err is discarded and never forwarded.
  - The aborted master sees stall = 1.
  - Exit to IDLE when the aborted master's cyc = 0; last_gnt = X, outstanding and watchdog cleared.
- Master cyc dropping with outstanding > 0 (a protocol violation): treated as a release; the slave cyc drops with it.
- Reset mid-transaction: all outputs return to their reset values asynchronously, and no ack is forwarded after reset.

Test Plan:
1. Single master: after reset, m0 issues read cyc with addr=0x0010_0004 and slave returns dat=0xDEADBEEF.
   -> gnt_o=01 one cycle after cyc; m0_dat_o=0xDEADBEEF with m0_ack_o; m1 sees stall=1.
2. Contention: m0 and m1 raise cyc in the same cycle and each does one write.
   -> m0 granted first; after m0 cyc drops, one IDLE cycle, then gnt_o=10.
   -> Repeat: m1 and m0 alternate over 4 rounds; round 3 starts with m0 (last_gnt was 1).
3. Pipelined burst: m0 issues 4 strobes back-to-back; the slave stalls 2 cycles on the 2nd strobe, then acks each strobe with 3-cycle latency.
   -> Exactly 4 acks reach m0; outstanding peaks at 3 and returns to 0.
4. Outstanding limit: with OW=2, m0 issues 5 strobes and the slave never acks.
   -> After 3 accepted strobes, m0_stall_o=1 and s_wb_stb_o=0.
5. Timeout: TIMEOUT=8; m1 issues 1 read and the slave never acks.
   -> m1_err_o pulses exactly once, 7 cycles after acceptance; s_wb_cyc_o=0.
   -> A slave ack arriving in ABORT is not seen by m1; the FSM returns to IDLE after m1 cyc drops.
6. Async reset: rst_n is pulled low mid-burst, between clock edges.
   -> s_wb_cyc_o=0, gnt_o=00 and all stalls=1 immediately; after release, m0 wins a simultaneous request.
